// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall/flush bit positions,
// bus widths, FSM state encoding and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int FLUSH_W = 5;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam int FLUSH_IF_ID  = 1;
    localparam int FLUSH_ID_EX  = 2;
    localparam int FLUSH_EX_MEM = 3;
    localparam int FLUSH_MEM_WB = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        JUMP_PEND = 2'd1,
        TRAP_WAIT = 2'd2
    } state_t;

    // The oldest stage asking to stall freezes itself and everything younger.
    function automatic logic [STALL_W-1:0] stall_encode(
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic mem_req
    );
        logic [STALL_W-1:0] s;
        if (mem_req) begin
            s = 6'b011111;
        end else if (ex_req) begin
            s = 6'b001111;
        end else if (id_req) begin
            s = 6'b000111;
        end else if (if_req) begin
            s = 6'b000011;
        end else begin
            s = 6'b000000;
        end
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_dff_lrc.sv
// Generic register cell with load enable and synchronous clear; async
// active-high reset to zero.
module pipe_ctrl_dff_lrc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage: clear takes precedence over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall/flush buses, PC redirect for jumps and
// traps, and a small FSM holding redirects that cannot complete at once.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall_req_i,
    input  logic               id_stall_req_i,
    input  logic               ex_stall_req_i,
    input  logic               mem_stall_req_i,
    input  logic               jump_req_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic               trap_req_i,
    input  logic [ADDR_W-1:0]  trap_addr_i,
    output logic [STALL_W-1:0] stall_o,
    output logic [FLUSH_W-1:0] flush_o,
    output logic               redirect_o,
    output logic [ADDR_W-1:0]  redirect_addr_o,
    output logic               trap_ack_o
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   pend_addr_r;
    logic [ADDR_W-1:0]   pend_d_s;
    logic                pend_load_s;
    logic [STALL_W-1:0]  stall_s;
    logic [FLUSH_W-1:0]  flush_s;
    logic                redirect_s;
    logic [ADDR_W-1:0]   redirect_addr_s;
    logic                trap_ack_s;
    logic                jump_ok_s;

    pipe_ctrl_dff_lrc #(.W(ADDR_W)) u_pend_addr (
        .clk  (clk),
        .rst  (rst),
        .load (pend_load_s),
        .clr  (1'b0),
        .d    (pend_d_s),
        .q    (pend_addr_r)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and combinational outputs; traps outrank jumps.
    always_comb begin
        state_nxt_s     = state_r;
        stall_s         = stall_encode(if_stall_req_i, id_stall_req_i,
                                       ex_stall_req_i, mem_stall_req_i);
        flush_s         = '0;
        redirect_s      = 1'b0;
        redirect_addr_s = '0;
        trap_ack_s      = 1'b0;
        pend_load_s     = 1'b0;
        pend_d_s        = jump_addr_i;
        jump_ok_s       = jump_req_i && !stall_s[STALL_EX];

        case (state_r)
            IDLE, JUMP_PEND: begin
                if (trap_req_i) begin
                    if (!mem_stall_req_i) begin
                        flush_s[FLUSH_EX_MEM:FLUSH_IF_ID] = 3'b111;
                        redirect_s      = 1'b1;
                        redirect_addr_s = trap_addr_i;
                        trap_ack_s      = 1'b1;
                        state_nxt_s     = IDLE;
                    end else begin
                        pend_load_s = 1'b1;
                        pend_d_s    = trap_addr_i;
                        state_nxt_s = TRAP_WAIT;
                    end
                end else if (state_r == JUMP_PEND) begin
                    // Younger instructions are flushed, so jump_req_i is not looked at here.
                    flush_s[FLUSH_IF_ID] = 1'b1;
                    redirect_s      = 1'b1;
                    redirect_addr_s = pend_addr_r;
                    if (!if_stall_req_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = JUMP_PEND;
                    end
                end else if (jump_ok_s) begin
                    flush_s[FLUSH_IF_ID] = 1'b1;
                    flush_s[FLUSH_ID_EX] = 1'b1;
                    redirect_s      = 1'b1;
                    redirect_addr_s = jump_addr_i;
                    if (if_stall_req_i) begin
                        pend_load_s = 1'b1;
                        pend_d_s    = jump_addr_i;
                        state_nxt_s = JUMP_PEND;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TRAP_WAIT: begin
                if (!mem_stall_req_i) begin
                    flush_s[FLUSH_EX_MEM:FLUSH_IF_ID] = 3'b111;
                    redirect_s      = 1'b1;
                    redirect_addr_s = pend_addr_r;
                    trap_ack_s      = 1'b1;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = TRAP_WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Reset forces every output low even while requests are asserted.
    assign stall_o         = rst ? '0   : stall_s;
    assign flush_o         = rst ? '0   : flush_s;
    assign redirect_o      = rst ? 1'b0 : redirect_s;
    assign redirect_addr_o = rst ? '0   : redirect_addr_s;
    assign trap_ack_o      = rst ? 1'b0 : trap_ack_s;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; inputs change on the falling edge and
// outputs are compared shortly after, before the next rising edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stall_req_i;
    logic        id_stall_req_i;
    logic        ex_stall_req_i;
    logic        mem_stall_req_i;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        trap_req_i;
    logic [31:0] trap_addr_i;
    logic [5:0]  stall_o;
    logic [4:0]  flush_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        trap_ack_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_stall_req_i  (if_stall_req_i),
        .id_stall_req_i  (id_stall_req_i),
        .ex_stall_req_i  (ex_stall_req_i),
        .mem_stall_req_i (mem_stall_req_i),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .trap_req_i      (trap_req_i),
        .trap_addr_i     (trap_addr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .trap_ack_o      (trap_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        if_stall_req_i  = 1'b0;
        id_stall_req_i  = 1'b0;
        ex_stall_req_i  = 1'b0;
        mem_stall_req_i = 1'b0;
        jump_req_i      = 1'b0;
        jump_addr_i     = 32'h0;
        trap_req_i      = 1'b0;
        trap_addr_i     = 32'h0;
    endtask

    // Step to the next falling edge so new inputs settle before the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [5:0] st, input logic [4:0] fl,
                             input logic rd, input logic [31:0] ad, input logic ak);
        #1;
        check_eq({tag, "_stall"}, {58'd0, stall_o}, {58'd0, st});
        check_eq({tag, "_flush"}, {59'd0, flush_o}, {59'd0, fl});
        check_eq({tag, "_redir"}, {63'd0, redirect_o}, {63'd0, rd});
        check_eq({tag, "_addr"}, {32'd0, redirect_addr_o}, {32'd0, ad});
        check_eq({tag, "_ack"}, {63'd0, trap_ack_o}, {63'd0, ak});
    endtask

    initial begin
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        // Reset with every request high.
        if_stall_req_i = 1'b1; id_stall_req_i = 1'b1; ex_stall_req_i = 1'b1;
        mem_stall_req_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h1234_5678;
        trap_req_i = 1'b1; trap_addr_i = 32'h8765_4321;
        check_all("reset", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); rst = 1'b0; clear_reqs();
        check_all("idle", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); id_stall_req_i = 1'b1;
        check_all("id_only", 6'b000111, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); clear_reqs(); if_stall_req_i = 1'b1; ex_stall_req_i = 1'b1;
        check_all("if_ex", 6'b001111, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); clear_reqs(); if_stall_req_i = 1'b1;
        check_all("if_only", 6'b000011, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); clear_reqs(); mem_stall_req_i = 1'b1;
        jump_req_i = 1'b1; jump_addr_i = 32'h8000_0080;
        check_all("jump_memstall", 6'b011111, 5'b00000, 1'b0, 32'h0, 1'b0);

        next_cycle(); clear_reqs();
        check_all("after_blocked_jump", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Jump with fetch idle.
        next_cycle(); jump_req_i = 1'b1; jump_addr_i = 32'h8000_0040;
        check_all("jump_fast", 6'b000000, 5'b00110, 1'b1, 32'h8000_0040, 1'b0);
        next_cycle(); clear_reqs();
        check_all("jump_fast_after", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Jump with fetch busy for three cycles.
        next_cycle(); jump_req_i = 1'b1; jump_addr_i = 32'h8000_0100; if_stall_req_i = 1'b1;
        check_all("jump_busy_c1", 6'b000011, 5'b00110, 1'b1, 32'h8000_0100, 1'b0);
        for (int i = 2; i <= 3; i++) begin
            next_cycle(); jump_req_i = 1'b0; jump_addr_i = 32'h0;
            check_all($sformatf("jump_busy_c%0d", i), 6'b000011, 5'b00010, 1'b1, 32'h8000_0100, 1'b0);
        end
        next_cycle(); if_stall_req_i = 1'b0;
        jump_req_i = 1'b1; jump_addr_i = 32'hDEAD_0000;
        check_all("jump_busy_c4", 6'b000000, 5'b00010, 1'b1, 32'h8000_0100, 1'b0);
        next_cycle(); clear_reqs();
        check_all("jump_busy_done", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Trap waiting two cycles on the LSU.
        next_cycle(); trap_req_i = 1'b1; trap_addr_i = 32'h8000_0004; mem_stall_req_i = 1'b1;
        check_all("trap_wait_c1", 6'b011111, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle(); trap_req_i = 1'b1; trap_addr_i = 32'h9999_9999;
        check_all("trap_wait_c2", 6'b011111, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle(); trap_req_i = 1'b0; mem_stall_req_i = 1'b0;
        check_all("trap_fire", 6'b000000, 5'b01110, 1'b1, 32'h8000_0004, 1'b1);
        next_cycle(); clear_reqs();
        check_all("trap_after", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Trap arriving while a jump is pending.
        next_cycle(); jump_req_i = 1'b1; jump_addr_i = 32'h8000_0200; if_stall_req_i = 1'b1;
        check_all("jp_start", 6'b000011, 5'b00110, 1'b1, 32'h8000_0200, 1'b0);
        next_cycle(); jump_req_i = 1'b0; trap_req_i = 1'b1; trap_addr_i = 32'h8000_0008;
        check_all("jp_trap", 6'b000011, 5'b01110, 1'b1, 32'h8000_0008, 1'b1);
        next_cycle(); trap_req_i = 1'b0; trap_addr_i = 32'h0;
        check_all("jp_dropped_busy", 6'b000011, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle(); if_stall_req_i = 1'b0;
        check_all("jp_dropped", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a trap wait.
        next_cycle(); trap_req_i = 1'b1; trap_addr_i = 32'h8000_000C; mem_stall_req_i = 1'b1;
        check_all("tw_enter", 6'b011111, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle(); trap_req_i = 1'b0; trap_addr_i = 32'h0;
        #2 rst = 1'b1;
        check_all("tw_reset", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle(); rst = 1'b0; mem_stall_req_i = 1'b0;
        check_all("tw_after_reset", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);
        next_cycle();
        check_all("tw_after_reset2", 6'b000000, 5'b00000, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller. Drives the stall[5:0] / flush[4:0] buses consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Drives the PC redirect used by jumps and traps.
- Arbitrates stage stall requests, ex-stage jumps and mem-stage traps.
- Holds redirects that cannot complete immediately in a small FSM.

Parameters:
ADDR_W, 32, width of PC / jump / trap target addresses (equals REG_BUS width)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_stall_req_i  in  1  fetch bus busy
id_stall_req_i  in  1  load-use / CSR hazard in decode
ex_stall_req_i  in  1  multi-cycle op (div) busy in execute
mem_stall_req_i  in  1  LSU bus busy in memory stage
jump_req_i  in  1  branch/jal taken, resolved in execute
jump_addr_i  in  ADDR_W  jump target
trap_req_i  in  1  exception/interrupt taken at memory stage
trap_addr_i  in  ADDR_W  trap vector
stall_o  out  6  bit k = stage k frozen (0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb)
flush_o  out  5  bit k = clear register after stage k (1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb; bit 0 unused, 0)
redirect_o  out  1  PC loads redirect_addr_o this cycle
redirect_addr_o  out  ADDR_W  new PC
trap_ack_o  out  1  one-cycle pulse, trap redirect performed

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
  - On reset: state=IDLE, pend_addr=0.
  - With state IDLE and all requests low, every output is 0.
- Outputs are combinational from the inputs and registered state. Same-cycle stall is required.
- Stall mapping: requester at stage s sets stall_o[s:0]=1. Highest requester wins. Priority mem(4) > ex(3) > id(2) > if(1).
  - mem -> 011111
  - ex -> 001111
  - id -> 000111
  - if -> 000011
  - stall_o[5] is always 0 (wb never stalls).
- Bubble insertion is done by the downstream registers from the stall pattern. pipe_ctrl adds no extra flush for stalls.
- jump qualifying: jump_req_i is acted on only when stall_o[3]==0. While ex or mem stalls, execute holds the instruction and re-asserts the request.
- Jump taken in IDLE:
  - flush_o[1]=flush_o[2]=1; redirect_o=1; redirect_addr_o=jump_addr_i.
  - If if_stall_req_i=1 the same cycle, latch jump_addr_i into pend_addr and go to JUMP_PEND.
- JUMP_PEND:
  - redirect_o=1, redirect_addr_o=pend_addr, flush_o[1]=1 every cycle.
  - Return to IDLE on the first cycle with if_stall_req_i=0; the redirect is consumed that cycle.
  - New jumps are ignored (younger instructions are flushed, so none can arrive).
- Trap in IDLE or JUMP_PEND, trap has priority over jump:
  - If mem_stall_req_i=0: flush_o[3:1]=111, redirect_o=1, redirect_addr_o=trap_addr_i, trap_ack_o=1. Next state IDLE; any pending jump is discarded.
  - If mem_stall_req_i=1: latch trap_addr_i into pend_addr, go to TRAP_WAIT.
- TRAP_WAIT:
  - stall_o=011111 and no flush while mem_stall_req_i=1.
  - On the first cycle mem_stall_req_i=0: flush_o[3:1]=111, redirect to pend_addr, trap_ack_o=1, go to IDLE.
  - trap_req_i is ignored in this state.
- Flush and stall conflict: if flush_o[k]=1 and stall_o[k]=1 the same cycle, flush wins at the register. pipe_ctrl still reports both.
- trap_ack_o is exactly one cycle per trap. redirect_o never asserts with redirect_addr_o undefined.
- Reset mid-JUMP_PEND or mid-TRAP_WAIT: the pending redirect is dropped; outputs go to 0 asynchronously.

Decomposition:
- Shared defines header: stall/flush bit indices (STALL_PC..STALL_WB, FLUSH_IF_ID..FLUSH_MEM_WB), STALL_W=6, FLUSH_W=5, FSM state encodings IDLE/JUMP_PEND/TRAP_WAIT (2-bit).
- pend_addr uses the existing dff_lrc register cell (load when latching, no clear needed).
- No other sub-module; stall priority encoder stays inline.

Test Plan:
- Reset and requests: rst=1 with all requests high -> all outputs 0. Release, assert id_stall_req_i alone -> stall_o=000111, flush_o=00000.
- Stall priority: if and ex requests together -> stall_o=001111. Jump with mem stalling -> no redirect, stall_o=011111.
- Jump, IFU idle: jump_req_i=1, jump_addr_i=0x80000040 -> same cycle redirect_o=1, addr 0x80000040, flush_o=00110. Next cycle all 0.
- Jump, IFU busy: jump 0x80000100 with if_stall_req_i held 3 cycles -> redirect_o=1, addr 0x80000100, flush_o[1]=1 for 4 cycles total. IDLE after if_stall_req_i drops.
- Trap waits for LSU: trap_req_i=1 with trap_addr_i=0x80000004 and mem_stall_req_i high 2 cycles -> stall_o=011111 for 2 cycles. Then flush_o=01110, redirect to 0x80000004, trap_ack_o pulses once.
- Trap with pending jump: trap during JUMP_PEND -> trap redirect wins; pending jump never reissued. Reset during TRAP_WAIT -> no trap_ack_o afterwards.
